// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg: shared state encoding and default parameters for the debounce bank
package debounce_bank_pkg;
  localparam int DEF_N_CH = 18;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [1:0] S_OFF = 2'b00;
  localparam logic [1:0] S_OFF_2_ON = 2'b01;
  localparam logic [1:0] S_ON = 2'b10;
  localparam logic [1:0] S_ON_2_OFF = 2'b11;
endpackage

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: switch inputs, threshold and debounced outputs of the bank
interface debounce_bank_if import debounce_bank_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
);
  logic [N_CH-1:0] noisy;
  logic [CNT_W-1:0] thresh;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic any_change;
  modport master(output noisy, thresh, input clean, rise, fall, any_change);
  modport slave(input noisy, thresh, output clean, rise, fall, any_change);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce fsm, counter and edge pulses for one switch
module debounce_channel import debounce_bank_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             noisy,
  input  logic [CNT_W-1:0] thresh,
  output logic             clean,
  output logic             rise,
  output logic             fall,
  output logic             event_nxt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync, done, rise_d, fall_d;
  logic [1:0] state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  assign sync = sync_q[SYNC_STAGES-1];
  assign clean = state[1];
  assign event_nxt = done;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
  always_comb begin
    done = ((state == S_OFF_2_ON && sync) || (state == S_ON_2_OFF && !sync)) && cnt >= thresh;
    state_d = state == S_OFF ? (sync ? S_OFF_2_ON : S_OFF) :
              state == S_ON ? (sync ? S_ON : S_ON_2_OFF) :
              state == S_OFF_2_ON ? (!sync ? S_OFF : done ? S_ON : S_OFF_2_ON) :
              (sync ? S_ON : done ? S_OFF : S_ON_2_OFF);
    cnt_d = (state[0] && state_d == state) ? cnt + CNT_W'(1) : '0;
    rise_d = done && state == S_OFF_2_ON;
    fall_d = done && state == S_ON_2_OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_OFF;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rise <= rise_d;
      fall <= fall_d;
    end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent switch debouncers with a shared any_change flag
module debounce_bank import debounce_bank_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic clk,
  input logic rst,
  debounce_bank_if.slave bus
);
  logic [N_CH-1:0] ev;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk(clk),
      .rst(rst),
      .noisy(bus.noisy[i]),
      .thresh(bus.thresh),
      .clean(bus.clean[i]),
      .rise(bus.rise[i]),
      .fall(bus.fall[i]),
      .event_nxt(ev[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.any_change <= 1'b0;
    else bus.any_change <= |ev;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: vector table plus event scoreboard for the debounce bank
module tb_debounce_bank;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SS = 2;
  typedef struct {int cyc; int ch; bit is_rise;} ev_t;
  typedef struct {logic [3:0] noisy; logic [7:0] thresh; int hold; logic [3:0] exp_clean;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit exp_any;
  ev_t e_mon;
  ev_t q[$];
  logic [3:0] ref_lvl = 4'b0000;
  vec_t vt[10];
  int t0;
  debounce_bank_if #(.N_CH(N), .CNT_W(W)) bus();
  debounce_bank #(.N_CH(N), .CNT_W(W), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  task automatic push(input int t, input int ch, input bit r);
    q.push_back('{t, ch, r});
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: ch %0d due cycle %0d not seen by cycle %0d", q[0].ch, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      exp_any = q.size() > 0 && q[0].cyc == cyc;
      chk("any_change", 32'(bus.any_change), 32'(exp_any));
      for (int c = 0; c < N; c++)
        if (bus.rise[c] || bus.fall[c]) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: ch %0d rise %0b fall %0b at cycle %0d, none expected", c, bus.rise[c], bus.fall[c], cyc);
          end else begin
            e_mon = q.pop_front();
            chk("ev_cyc", 32'(cyc), 32'(e_mon.cyc));
            chk("ev_ch_kind", {8'(c), 6'd0, bus.rise[c], bus.fall[c]}, {8'(e_mon.ch), 6'd0, e_mon.is_rise, !e_mon.is_rise});
          end
        end
    end
  end
  initial begin
    vt[0] = '{4'b0001, 8'd10, 16, 4'b0001};
    vt[1] = '{4'b0011, 8'd10, 8, 4'b0001};
    vt[2] = '{4'b0001, 8'd10, 16, 4'b0001};
    vt[3] = '{4'b1001, 8'd10, 16, 4'b1001};
    vt[4] = '{4'b0110, 8'd10, 16, 4'b0110};
    vt[5] = '{4'b0100, 8'd3, 8, 4'b0100};
    vt[6] = '{4'b1100, 8'd0, 5, 4'b1100};
    vt[7] = '{4'b0000, 8'd0, 5, 4'b0000};
    vt[8] = '{4'b0100, 8'd0, 5, 4'b0100};
    vt[9] = '{4'b0000, 8'd10, 16, 4'b0000};
    bus.noisy = '0;
    bus.thresh = 8'd10;
    repeat (2) @(negedge clk);
    chk("reset_clean", 32'(bus.clean), 0);
    chk("reset_pulses", {bus.rise, bus.fall, 3'b000, bus.any_change}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.thresh = vt[i].thresh;
      bus.noisy = vt[i].noisy;
      for (int c = 0; c < N; c++)
        if (vt[i].noisy[c] != ref_lvl[c] && vt[i].hold >= SS + int'(vt[i].thresh) + 2) begin
          push(cyc + SS + int'(vt[i].thresh) + 2, c, vt[i].noisy[c]);
          ref_lvl[c] = vt[i].noisy[c];
        end
      repeat (vt[i].hold) @(negedge clk);
      chk($sformatf("vec%0d_clean", i), 32'(bus.clean), 32'(vt[i].exp_clean));
    end
    bus.noisy = 4'b0001;
    t0 = cyc;
    push(t0 + 14, 0, 1'b1);
    repeat (13) @(negedge clk);
    chk("edge_clean_early", 32'(bus.clean), 0);
    @(negedge clk);
    chk("edge_clean_14", 32'(bus.clean), 32'h1);
    repeat (2) @(negedge clk);
    chk("edge_clean_hold", 32'(bus.clean), 32'h1);
    bus.noisy = 4'b0101;
    t0 = cyc;
    repeat (8) @(negedge clk);
    chk("lower_pending", 32'(bus.clean), 32'h1);
    bus.thresh = 8'd2;
    push(t0 + 9, 2, 1'b1);
    repeat (3) @(negedge clk);
    chk("lower_clean", 32'(bus.clean), 32'h5);
    bus.thresh = 8'd10;
    bus.noisy = 4'b1101;
    push(cyc + 14, 3, 1'b1);
    repeat (16) @(negedge clk);
    chk("ch3_on", 32'(bus.clean), 32'hd);
    bus.noisy = 4'b0111;
    push(cyc + 14, 1, 1'b1);
    push(cyc + 14, 3, 1'b0);
    repeat (16) @(negedge clk);
    chk("swap_clean", 32'(bus.clean), 32'h7);
    bus.noisy = 4'b1111;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    q.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_clean", 32'(bus.clean), 0);
    chk("async_rst_pulses", {bus.rise, bus.fall, 3'b000, bus.any_change}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    t0 = cyc;
    for (int c = 0; c < N; c++) push(t0 + 14, c, 1'b1);
    repeat (13) @(negedge clk);
    chk("post_rst_early", 32'(bus.clean), 0);
    @(negedge clk);
    chk("post_rst_clean", 32'(bus.clean), 32'hf);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 18, number of independent switch channels (1..32).
REQ-002 Parameter CNT_W, default 20, width of the debounce counter and threshold.
REQ-003 Parameter SYNC_STAGES, default 2, number of synchroniser flops per channel (2..4).
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 noisy  input  N_CH  raw, asynchronous switch levels.
REQ-008 thresh  input  CNT_W  stable-time threshold in clk cycles, sampled live every cycle.
REQ-009 clean  output  N_CH  debounced levels, registered.
REQ-010 rise  output  N_CH  one-cycle pulse when clean[i] goes 0->1, registered.
REQ-011 fall  output  N_CH  one-cycle pulse when clean[i] goes 1->0, registered.
REQ-012 any_change  output  1  OR of all rise and fall bits, registered in the same cycle as those bits.

Function
REQ-013 Each channel SHALL pass noisy[i] through SYNC_STAGES flops; only the last stage (sync[i]) feeds the FSM.
REQ-014 Each channel SHALL have FSM states OFF, OFF_2_ON, ON, ON_2_OFF and a CNT_W-bit counter.
REQ-015 OFF: counter=0; sync=1 -> OFF_2_ON, else stay. ON: counter=0; sync=0 -> ON_2_OFF, else stay.
REQ-016 OFF_2_ON, when sync=0, SHALL abort to OFF, clear the counter, and produce no pulse.
REQ-017 OFF_2_ON, when sync=1 and counter>=thresh, SHALL go to ON, set clean=1, and pulse rise for one cycle; otherwise counter+1.
REQ-018 ON_2_OFF SHALL mirror REQ-016/017, with levels inverted and the fall pulse.
REQ-019 clean SHALL be 1 exactly in states ON and ON_2_OFF, and 0 in OFF and OFF_2_ON.
REQ-020 Latency from a held raw edge to clean/pulse SHALL be SYNC_STAGES+thresh+2 cycles.
REQ-021 With thresh=0, the transition SHALL complete on the first cycle in the pending state, a latency of SYNC_STAGES+2.
REQ-022 The counter SHALL never exceed thresh, so it never wraps.
REQ-023 If thresh is lowered below the current count, the transition SHALL complete on the next cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-025 rise[i] and fall[i] SHALL never be high together.

Reset
REQ-026 rst=1 SHALL immediately force all synchroniser flops=0, all states=OFF, all counters=0, clean=0, rise=0, fall=0 and any_change=0.
REQ-027 A reset during a pending state SHALL discard that progress; after release, a still-high input SHALL be debounced over the full REQ-020 latency.

Structure
REQ-028 A shared package SHALL hold the 2-bit state encoding (OFF, OFF_2_ON, ON, ON_2_OFF) and the default parameter constants.
REQ-029 One sub-module, debounce_channel, SHALL hold the synchroniser, FSM, counter and pulse logic for one channel.
REQ-030 debounce_bank SHALL generate N_CH copies of debounce_channel and form any_change from their outputs.

Verification (N_CH=4, CNT_W=8, SYNC_STAGES=2, thresh=10)
REQ-031 Reset: assert rst mid-run -> all outputs 0 within the same cycle, with no clock edge needed.
REQ-032 Hold noisy[0] 0->1 -> clean[0]=1, rise[0] and any_change each high for exactly 1 cycle, 14 cycles after the raw edge.
REQ-033 Glitch: noisy[1] high for 8 cycles, then low -> clean[1] stays 0 and no pulse occurs.
REQ-034 Set thresh=0 and toggle noisy[2] high -> clean[2]=1 after 4 cycles.
REQ-035 With clean[3]=1, drop noisy[3] while raising noisy[0] in the same cycle -> fall[3] and rise[0] pulse in the same cycle, and any_change pulses once.
REQ-036 Assert rst 6 cycles into a pending rise with the input held high -> clean=0; after release, rise occurs 14 cycles later.
